// File: rtl/fifo_read_adapter_pkg.sv
// Shared types, defaults and the read-credit rule for the FIFO read adapter.
package fifo_read_adapter_pkg;

    localparam int DW_DEFAULT        = 8;
    localparam int BUF_DEPTH_DEFAULT = 4;
    localparam int CW_DEFAULT        = 16;

    typedef logic [DW_DEFAULT-1:0] word_t;

    // A new read may only be issued if the word it returns is guaranteed a slot.
    function automatic logic credit_ok(input int occ, input logic inflight,
                                       input int depth = BUF_DEPTH_DEFAULT);
        return (occ + int'(inflight)) < depth;
    endfunction

endpackage

// File: rtl/fifo_read_adapter_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the adapter.
interface fifo_read_adapter_if #(
    parameter int DW = fifo_read_adapter_pkg::DW_DEFAULT
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    // Stream: a word transfers on every edge where m_valid & m_ready; once
    // m_valid is high it stays high with m_data unchanged until that transfer.
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd, m_valid, m_data
    );
endinterface

// File: rtl/fifo_read_adapter_rd_skid_buf.sv
// Circular skid buffer catching FIFO read data; head is always the oldest word.
module rd_skid_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   occ,
    output logic [DW-1:0]            head
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_adapter.sv
// Issues FIFO reads against buffer credit, absorbs the 1-cycle read latency and
// streams words downstream at up to one per cycle.
module fifo_read_adapter
    import fifo_read_adapter_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    parameter int CW        = CW_DEFAULT
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 enable,
    fifo_read_adapter_if.master  bus,
    output logic [CW-1:0]        pop_count
);
    localparam int OW = $clog2(BUF_DEPTH) + 1;

    logic          run;
    logic          inflight;
    logic          handshake;
    logic [OW-1:0] occ;
    logic [DW-1:0] head;

    // run holds reads off for the first cycle after reset release.
    always_comb begin
        bus.fifo_rd = run & enable & ~bus.fifo_empty
                      & credit_ok(int'(occ), inflight, BUF_DEPTH);
    end

    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = head;
    assign handshake   = bus.m_valid & bus.m_ready;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            inflight  <= 1'b0;
            pop_count <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= bus.fifo_rd;
            if (handshake) pop_count <= pop_count + CW'(1);
        end
    end

    rd_skid_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clock     (clock),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .pop       (handshake),
        .occ       (occ),
        .head      (head)
    );

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Directed bench: behavioural 1-cycle-latency FIFO feeding the adapter.
module tb_fifo_read_adapter;

    logic        clock;
    logic        rst;
    logic        enable;
    logic [15:0] pop_count;

    fifo_read_adapter_if #(.DW(8)) bus ();

    fifo_read_adapter dut (
        .clock     (clock),
        .rst       (rst),
        .enable    (enable),
        .bus       (bus.master),
        .pop_count (pop_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FIFO model
    logic [7:0] fmem [64];
    logic [6:0] fw, fr;
    logic [7:0] fdout;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fake_full;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            fw    <= '0;
            fr    <= '0;
            fdout <= '0;
        end else begin
            if (wr_en) begin
                fmem[fw[5:0]] <= wr_data;
                fw <= fw + 7'd1;
            end
            if (bus.fifo_rd) begin
                fdout <= fmem[fr[5:0]];
                fr <= fr + 7'd1;
            end
        end
    end

    assign bus.fifo_empty = (fw == fr) & ~fake_full;
    assign bus.fifo_data  = fdout;

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    int checks = 0;
    int errors = 0;

    // drivers
    task automatic do_reset();
        @(negedge clock);
        rst = 1'b0; enable = 1'b0; bus.m_ready = 1'b0;
        wr_en = 1'b0; fake_full = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
    endtask

    task automatic write_fifo(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            wr_en = 1'b1;
            wr_data = first + 8'(i);
        end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst = 1'b0; fake_full = 1'b1; enable = 1'b1; bus.m_ready = 1'b1;
        #1;
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.fifo_rd); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
        checks++; if (pop_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pop_count); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.m_data); end
        @(negedge clock);
        rst = 1'b1;
        #1;
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL release_rd_edge1: got %b want 0", bus.fifo_rd); end
        @(negedge clock);
        #1;
        checks++; if (bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL release_rd_edge2: got %b want 1", bus.fifo_rd); end
        rst = 1'b0;
        fake_full = 1'b0;
        do_reset();
    endtask

    task automatic test_stream();
        int n = 0, first = -1, last = -1;
        do_reset();
        bus.m_ready = 1'b1;
        write_fifo(8'h01, 32);
        for (int i = 1; i <= 32; i++) exp_q.push_back(8'(i));
        enable = 1'b1;
        for (int c = 0; c < 80; c++) begin
            #1;
            checks++; if (bus.fifo_rd && bus.fifo_empty) begin errors++; $display("FAIL stream_underflow: rd=1 empty=1 at cycle %0d, want rd=0", c); end
            if (bus.m_valid && bus.m_ready) begin
                n++;
                if (first < 0) first = c;
                last = c;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra: got %h want none", bus.m_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin errors++; $display("FAIL stream_data: got %h want %h", bus.m_data, exp_w); end
                end
            end
            @(negedge clock);
        end
        checks++; if (n != 32) begin errors++; $display("FAIL stream_count: got %0d want 32", n); end
        checks++; if (last - first != 31) begin errors++; $display("FAIL stream_rate: span %0d want 31", last - first); end
        checks++; if (pop_count !== 16'd32) begin errors++; $display("FAIL stream_pop_count: got %0d want 32", pop_count); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b want 0", bus.m_valid); end
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0, n = 0;
        logic seen = 1'b0, stable = 1'b1;
        do_reset();
        write_fifo(8'h01, 10);
        for (int i = 1; i <= 10; i++) exp_q.push_back(8'(i));
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.fifo_rd) rd_cnt++;
            if (seen && !bus.m_valid) stable = 1'b0;
            if (bus.m_valid) begin
                seen = 1'b1;
                if (bus.m_data !== 8'h01) stable = 1'b0;
            end
            @(negedge clock);
        end
        checks++; if (rd_cnt != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", rd_cnt); end
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h01) begin errors++; $display("FAIL bp_data: got %h want 01", bus.m_data); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", stable); end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.m_valid) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want none", bus.m_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin errors++; $display("FAIL bp_drain_data: got %h want %h", bus.m_data, exp_w); end
                end
            end
            @(negedge clock);
        end
        checks++; if (n != 10) begin errors++; $display("FAIL bp_drain_count: got %0d want 10", n); end
        checks++; if (pop_count !== 16'd10) begin errors++; $display("FAIL bp_pop_count: got %0d want 10", pop_count); end
    endtask

    task automatic test_empty_boundary();
        int rd_cnt = 0, rd_cyc = -1, v_cnt = 0, v_cyc = -1;
        logic [7:0] v_data = 8'h00;
        do_reset();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        write_fifo(8'hA5, 1);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.fifo_rd) begin rd_cnt++; if (rd_cyc < 0) rd_cyc = c; end
            if (bus.m_valid) begin v_cnt++; if (v_cyc < 0) begin v_cyc = c; v_data = bus.m_data; end end
            @(negedge clock);
        end
        checks++; if (rd_cnt != 1) begin errors++; $display("FAIL edge_reads: got %0d want 1", rd_cnt); end
        checks++; if (v_cyc - rd_cyc != 2) begin errors++; $display("FAIL edge_latency: got %0d want 2", v_cyc - rd_cyc); end
        checks++; if (v_data !== 8'hA5) begin errors++; $display("FAIL edge_data: got %h want a5", v_data); end
        checks++; if (v_cnt != 1) begin errors++; $display("FAIL edge_valid_cycles: got %0d want 1", v_cnt); end
        checks++; if (pop_count !== 16'd1) begin errors++; $display("FAIL edge_pop_count: got %0d want 1", pop_count); end
    endtask

    task automatic test_enable_toggle();
        int rd_cnt = 0, n = 0;
        do_reset();
        bus.m_ready = 1'b1;
        write_fifo(8'h31, 3);
        exp_q.push_back(8'h31);
        enable = 1'b1;
        #1;
        checks++; if (bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL en_first_rd: got %b want 1", bus.fifo_rd); end
        @(posedge clock);
        #1 enable = 1'b0;
        @(negedge clock);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.fifo_rd) rd_cnt++;
            if (bus.m_valid) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL en_extra: got %h want none", bus.m_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin errors++; $display("FAIL en_inflight_data: got %h want %h", bus.m_data, exp_w); end
                end
            end
            @(negedge clock);
        end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL en_no_reads: got %0d want 0", rd_cnt); end
        checks++; if (n != 1) begin errors++; $display("FAIL en_inflight_count: got %0d want 1", n); end
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        n = 0;
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.m_valid) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL en_resume_extra: got %h want none", bus.m_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin errors++; $display("FAIL en_resume_data: got %h want %h", bus.m_data, exp_w); end
                end
            end
            @(negedge clock);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL en_resume_count: got %0d want 2", n); end
        checks++; if (pop_count !== 16'd3) begin errors++; $display("FAIL en_pop_count: got %0d want 3", pop_count); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        write_fifo(8'h61, 4);
        enable = 1'b1;
        repeat (8) @(negedge clock);
        bus.m_ready = 1'b1;
        #1;
        checks++; if (bus.m_data !== 8'h61) begin errors++; $display("FAIL ar_first: got %h want 61", bus.m_data); end
        @(negedge clock);
        bus.m_ready = 1'b0;
        #1;
        checks++; if (pop_count !== 16'd1) begin errors++; $display("FAIL ar_pre_count: got %0d want 1", pop_count); end
        checks++; if (bus.m_data !== 8'h62) begin errors++; $display("FAIL ar_pre_data: got %h want 62", bus.m_data); end
        @(posedge clock);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL ar_data: got %h want 00", bus.m_data); end
        checks++; if (pop_count !== 16'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", pop_count); end
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL ar_rd: got %b want 0", bus.fifo_rd); end
        @(negedge clock);
        rst = 1'b1;
        enable = 1'b0;
        write_fifo(8'h71, 2);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h72);
        bus.m_ready = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (bus.m_valid) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL ar_extra: got %h want none", bus.m_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin errors++; $display("FAIL ar_post_data: got %h want %h", bus.m_data, exp_w); end
                end
            end
            @(negedge clock);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL ar_post_count: got %0d want 2", n); end
        checks++; if (pop_count !== 16'd2) begin errors++; $display("FAIL ar_pop_count: got %0d want 2", pop_count); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; bus.m_ready = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; fake_full = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_boundary();
        test_enable_toggle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
